ex_mem_stage: RTL and testbench

- EX→MEM pipeline stage directly downstream of the 64-bit ALU; captures ALU_OUTPUT/Zero plus forwarded control, resolves B/CBZ/CBNZ and presents a registered record to the data-memory stage.
- Ready/valid on both sides with a 2-entry skid buffer, so the ALU never stalls combinationally on MEM_READY and sustains one op/cycle.

---
 rtl/arm_pkg.sv | 46 ++++
 rtl/ex_mem_stage_if.sv | 39 +++
 rtl/ex_mem_skid.sv | 91 +++++++++
 rtl/ex_mem_stage.sv | 60 ++++++
 tb/tb_ex_mem_stage.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/arm_pkg.sv
// Shared encodings for the ARM-style pipeline: branch types, CTRL bit positions,
// ALU function codes, skid states and the EX/MEM record width.
package arm_pkg;

    localparam int unsigned ARM_DATA_W  = 64;
    localparam int unsigned ARM_REG_W   = 5;
    localparam int unsigned ARM_CTRL_W  = 4;
    localparam int unsigned ARM_BRT_W   = 2;

    // CTRL = {MEM_READ, MEM_WRITE, REG_WRITE, MEM_TO_REG}
    localparam int unsigned CTRL_MEM_READ   = 3;
    localparam int unsigned CTRL_MEM_WRITE  = 2;
    localparam int unsigned CTRL_REG_WRITE  = 1;
    localparam int unsigned CTRL_MEM_TO_REG = 0;

    localparam int unsigned EX_MEM_REC_W = 2 * ARM_DATA_W + ARM_REG_W + ARM_CTRL_W;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_B    = 2'b01,
        BR_CBZ  = 2'b10,
        BR_CBNZ = 2'b11
    } br_type_e;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_SUB   = 4'b0110,
        ALU_PASSB = 4'b0111,
        ALU_NOR   = 4'b1100
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b10
    } skid_state_e;

    function automatic logic br_taken(input logic [ARM_BRT_W-1:0] br_type, input logic zero);
        return (br_type == BR_B) ||
               ((br_type == BR_CBZ) && zero) ||
               ((br_type == BR_CBNZ) && !zero);
    endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX->MEM stage bus: upstream ALU handshake, downstream memory record and branch outputs.
interface ex_mem_stage_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned REG_W  = 5
);
    logic              FLUSH;
    logic              EX_VALID;
    logic              EX_READY;
    logic [DATA_W-1:0] ALU_OUTPUT;
    logic              ZERO;
    logic [DATA_W-1:0] PC;
    logic [DATA_W-1:0] BR_OFFSET;
    logic [1:0]        BR_TYPE;
    logic [DATA_W-1:0] STORE_DATA;
    logic [REG_W-1:0]  RD;
    logic [3:0]        CTRL;
    logic              MEM_VALID;
    logic              MEM_READY;
    logic [DATA_W-1:0] MEM_ALU;
    logic [DATA_W-1:0] MEM_STORE;
    logic [REG_W-1:0]  MEM_RD;
    logic [3:0]        MEM_CTRL;
    logic              BRANCH_TAKEN;
    logic [DATA_W-1:0] BR_TARGET;

    modport master (
        output FLUSH, EX_VALID, ALU_OUTPUT, ZERO, PC, BR_OFFSET, BR_TYPE,
               STORE_DATA, RD, CTRL, MEM_READY,
        input  EX_READY, MEM_VALID, MEM_ALU, MEM_STORE, MEM_RD, MEM_CTRL,
               BRANCH_TAKEN, BR_TARGET
    );

    modport slave (
        input  FLUSH, EX_VALID, ALU_OUTPUT, ZERO, PC, BR_OFFSET, BR_TYPE,
               STORE_DATA, RD, CTRL, MEM_READY,
        output EX_READY, MEM_VALID, MEM_ALU, MEM_STORE, MEM_RD, MEM_CTRL,
               BRANCH_TAKEN, BR_TARGET
    );
endinterface

// File: rtl/ex_mem_skid.sv
// Generic 2-entry ready/valid skid buffer; ready and valid are both registered so
// the upstream never sees a combinational path from out_ready_i.
module ex_mem_skid
    import arm_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    skid_state_e  state_q, state_d;
    logic         ready_q, valid_q;
    logic [W-1:0] main_q, skid_q;
    logic         accept_c, drain_c;
    logic         load_main_c, load_skid_c, move_c;

    assign accept_c = in_valid_i && ready_q && !flush_i;
    assign drain_c  = valid_q && out_ready_i;

    // State register, with ready/valid registered from the next state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SKID_EMPTY;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != SKID_FULL);
            valid_q <= (state_d != SKID_EMPTY);
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: if (accept_c) state_d = SKID_ONE;
                SKID_ONE: begin
                    if (accept_c && !drain_c)      state_d = SKID_FULL;
                    else if (drain_c && !accept_c) state_d = SKID_EMPTY;
                end
                SKID_FULL:  if (drain_c) state_d = SKID_ONE;
                default:    state_d = SKID_EMPTY;
            endcase
        end
    end

    // Datapath load enables; the skid slot only refills main, keeping FIFO order
    always_comb begin
        load_main_c = 1'b0;
        load_skid_c = 1'b0;
        move_c      = 1'b0;
        if (!flush_i) begin
            case (state_q)
                SKID_EMPTY: load_main_c = accept_c;
                SKID_ONE: begin
                    load_main_c = accept_c && drain_c;
                    load_skid_c = accept_c && !drain_c;
                end
                SKID_FULL:  move_c = drain_c;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_c)  main_q <= in_data_i;
            else if (move_c)  main_q <= skid_q;
            if (load_skid_c)  skid_q <= in_data_i;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = valid_q;
    assign out_data_o  = main_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage: resolves B/CBZ/CBNZ at capture, packs the memory record
// and buffers it through a 2-entry skid toward the data-memory stage.
module ex_mem_stage
    import arm_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned REG_W  = 5
) (
    input  logic           CLK,
    input  logic           RESET,
    ex_mem_stage_if.slave  bus
);

    localparam int unsigned REC_W = 2 * DATA_W + REG_W + ARM_CTRL_W;

    logic [REC_W-1:0]  in_rec_c, out_rec;
    logic              ex_ready;
    logic              accept_c, taken_c;
    logic [DATA_W-1:0] target_c;
    logic              br_taken_q;
    logic [DATA_W-1:0] br_target_q;

    assign in_rec_c = {bus.ALU_OUTPUT, bus.STORE_DATA, bus.RD, bus.CTRL};

    ex_mem_skid #(.W(REC_W)) u_skid (
        .clk_i       (CLK),
        .rst_i       (RESET),
        .flush_i     (bus.FLUSH),
        .in_valid_i  (bus.EX_VALID),
        .in_ready_o  (ex_ready),
        .in_data_i   (in_rec_c),
        .out_valid_o (bus.MEM_VALID),
        .out_ready_i (bus.MEM_READY),
        .out_data_o  (out_rec)
    );

    assign accept_c = bus.EX_VALID && ex_ready && !bus.FLUSH;
    assign taken_c  = br_taken(bus.BR_TYPE, bus.ZERO);
    assign target_c = bus.PC + (bus.BR_OFFSET << 2);

    // Branch pulse fires once per taken capture; the target persists until the next one
    always_ff @(posedge CLK) begin
        if (RESET) begin
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
        end else begin
            br_taken_q <= accept_c && taken_c;
            if (accept_c && taken_c) br_target_q <= target_c;
        end
    end

    assign bus.EX_READY     = ex_ready;
    assign bus.MEM_ALU      = out_rec[REC_W-1 -: DATA_W];
    assign bus.MEM_STORE    = out_rec[DATA_W+REG_W+ARM_CTRL_W-1 -: DATA_W];
    assign bus.MEM_RD       = out_rec[REG_W+ARM_CTRL_W-1 -: REG_W];
    assign bus.MEM_CTRL     = out_rec[ARM_CTRL_W-1:0];
    assign bus.BRANCH_TAKEN = br_taken_q;
    assign bus.BR_TARGET    = br_target_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed literal checks plus randomized traffic against
// a queue-based occupancy/branch model compared every cycle.
module tb_ex_mem_stage;

    logic CLK = 1'b0;
    logic RESET;

    ex_mem_stage_if #(.DATA_W(64), .REG_W(5)) bus();

    ex_mem_stage #(.DATA_W(64), .REG_W(5)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [63:0] alu;
        logic [63:0] st;
        logic [4:0]  rd;
        logic [3:0]  ctrl;
    } rec_t;

    int          total = 0;
    int          bad   = 0;
    bit          chk_en = 1'b0;
    rec_t        mq[$];
    logic        m_ready  = 1'b1;
    logic        m_pulse  = 1'b0;
    logic [63:0] m_target = 64'd0;

    function automatic logic is_taken(input logic [1:0] t, input logic z);
        return (t == 2'd1) || (t == 2'd2 && z) || (t == 2'd3 && !z);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] alu, input logic z,
                         input logic [63:0] pc, input logic [63:0] off, input logic [1:0] bt,
                         input logic [63:0] st, input logic [4:0] rd, input logic [3:0] ctrl);
        bus.EX_VALID   = v;
        bus.ALU_OUTPUT = alu;
        bus.ZERO       = z;
        bus.PC         = pc;
        bus.BR_OFFSET  = off;
        bus.BR_TYPE    = bt;
        bus.STORE_DATA = st;
        bus.RD         = rd;
        bus.CTRL       = ctrl;
    endtask

    task automatic idle();
        drive(1'b0, 64'd0, 1'b0, 64'd0, 64'd0, 2'd0, 64'd0, 5'd0, 4'd0);
    endtask

    // Reference: FIFO of accepted records, at most two in flight
    always @(posedge CLK) begin : model
        logic acc, drn;
        if (RESET) begin
            mq.delete();
            m_ready  = 1'b1;
            m_pulse  = 1'b0;
            m_target = 64'd0;
        end else begin
            acc = bus.EX_VALID && m_ready && !bus.FLUSH;
            drn = (mq.size() > 0) && bus.MEM_READY;
            m_pulse = acc && is_taken(bus.BR_TYPE, bus.ZERO);
            if (m_pulse) m_target = bus.PC + bus.BR_OFFSET * 64'd4;
            if (bus.FLUSH) begin
                mq.delete();
            end else begin
                if (drn) void'(mq.pop_front());
                if (acc) mq.push_back(rec_t'{alu: bus.ALU_OUTPUT, st: bus.STORE_DATA,
                                             rd: bus.RD, ctrl: bus.CTRL});
            end
            m_ready = (mq.size() < 2);
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("ex_ready",     64'(bus.EX_READY),     64'(m_ready));
            chk("mem_valid",    64'(bus.MEM_VALID),    64'(mq.size() > 0));
            chk("branch_taken", 64'(bus.BRANCH_TAKEN), 64'(m_pulse));
            chk("br_target",    bus.BR_TARGET,         m_target);
            if (mq.size() > 0) begin
                chk("mem_alu",   bus.MEM_ALU,          mq[0].alu);
                chk("mem_store", bus.MEM_STORE,        mq[0].st);
                chk("mem_rd",    64'(bus.MEM_RD),      64'(mq[0].rd));
                chk("mem_ctrl",  64'(bus.MEM_CTRL),    64'(mq[0].ctrl));
            end
        end
    end

    initial begin
        RESET = 1'b1;
        bus.FLUSH = 1'b0;
        bus.MEM_READY = 1'b1;
        idle();
        @(posedge CLK);
        chk_en = 1'b1;
        @(negedge CLK);
        chk("rst_ready",  64'(bus.EX_READY),     64'd1);
        chk("rst_valid",  64'(bus.MEM_VALID),    64'd0);
        chk("rst_pulse",  64'(bus.BRANCH_TAKEN), 64'd0);
        chk("rst_alu",    bus.MEM_ALU,           64'd0);
        chk("rst_target", bus.BR_TARGET,         64'd0);

        // Single ADD
        #1 RESET = 1'b0;
        drive(1'b1, 64'h5, 1'b0, 64'd0, 64'd0, 2'b00, 64'd0, 5'd3, 4'b0010);
        @(negedge CLK);
        chk("add_valid", 64'(bus.MEM_VALID),    64'd1);
        chk("add_alu",   bus.MEM_ALU,           64'h5);
        chk("add_rd",    64'(bus.MEM_RD),       64'd3);
        chk("add_pulse", 64'(bus.BRANCH_TAKEN), 64'd0);

        // CBZ taken, then CBZ not taken
        #1 drive(1'b1, 64'd0, 1'b1, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFC, 2'b10, 64'd0, 5'd0, 4'd0);
        @(negedge CLK);
        chk("cbz_pulse",  64'(bus.BRANCH_TAKEN), 64'd1);
        chk("cbz_target", bus.BR_TARGET,         64'h0FF0);
        #1 idle();
        @(negedge CLK);
        chk("cbz_pulse_end", 64'(bus.BRANCH_TAKEN), 64'd0);
        #1 drive(1'b1, 64'd0, 1'b0, 64'h2000, 64'h10, 2'b10, 64'd0, 5'd0, 4'd0);
        @(negedge CLK);
        chk("cbz_nt_pulse",  64'(bus.BRANCH_TAKEN), 64'd0);
        chk("cbz_nt_target", bus.BR_TARGET,         64'h0FF0);

        // Unconditional B with wrapping target
        #1 drive(1'b1, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h4, 2'b01, 64'd0, 5'd0, 4'd0);
        @(negedge CLK);
        chk("wrap_pulse",  64'(bus.BRANCH_TAKEN), 64'd1);
        chk("wrap_target", bus.BR_TARGET,         64'h8);
        #1 idle();
        repeat (3) @(negedge CLK);

        // Backpressure: A, B, C with MEM_READY low
        #1 bus.MEM_READY = 1'b0;
        drive(1'b1, 64'hA1, 1'b0, 64'd0, 64'd0, 2'b00, 64'h11, 5'd1, 4'b0010);
        @(negedge CLK);
        chk("bp_a_alu",   bus.MEM_ALU,       64'hA1);
        chk("bp_a_ready", 64'(bus.EX_READY), 64'd1);
        #1 drive(1'b1, 64'hB2, 1'b0, 64'd0, 64'd0, 2'b00, 64'h22, 5'd2, 4'b0010);
        @(negedge CLK);
        chk("bp_full_ready", 64'(bus.EX_READY), 64'd0);
        chk("bp_hold_a",     bus.MEM_ALU,       64'hA1);
        #1 drive(1'b1, 64'hC3, 1'b0, 64'd0, 64'd0, 2'b00, 64'h33, 5'd4, 4'b0010);
        @(negedge CLK);
        @(negedge CLK);
        chk("bp_hold_a2",  bus.MEM_ALU,       64'hA1);
        chk("bp_c_held",   64'(bus.EX_READY), 64'd0);
        #1 bus.MEM_READY = 1'b1;
        @(negedge CLK);
        chk("bp_b_alu",    bus.MEM_ALU,       64'hB2);
        chk("bp_b_ready",  64'(bus.EX_READY), 64'd1);
        @(negedge CLK);
        chk("bp_c_alu",    bus.MEM_ALU,       64'hC3);
        #1 idle();
        @(negedge CLK);
        chk("bp_empty",    64'(bus.MEM_VALID), 64'd0);

        // FLUSH while FULL with a taken B offered
        #1 bus.MEM_READY = 1'b0;
        drive(1'b1, 64'hD4, 1'b0, 64'd0, 64'd0, 2'b00, 64'd0, 5'd5, 4'b1010);
        @(negedge CLK);
        #1 drive(1'b1, 64'hE5, 1'b0, 64'd0, 64'd0, 2'b00, 64'd0, 5'd6, 4'b0100);
        @(negedge CLK);
        chk("fl_pre_ready", 64'(bus.EX_READY), 64'd0);
        #1 bus.FLUSH = 1'b1;
        drive(1'b1, 64'd0, 1'b0, 64'h4000, 64'h1, 2'b01, 64'd0, 5'd0, 4'd0);
        @(negedge CLK);
        chk("fl_valid",  64'(bus.MEM_VALID),    64'd0);
        chk("fl_ready",  64'(bus.EX_READY),     64'd1);
        chk("fl_pulse",  64'(bus.BRANCH_TAKEN), 64'd0);
        chk("fl_target", bus.BR_TARGET,         64'h8);

        // Taken capture followed by FLUSH keeps its pulse and target
        #1 bus.FLUSH = 1'b0;
        bus.MEM_READY = 1'b1;
        drive(1'b1, 64'd0, 1'b0, 64'h100, 64'h2, 2'b01, 64'd0, 5'd0, 4'd0);
        @(negedge CLK);
        chk("fp_pulse",  64'(bus.BRANCH_TAKEN), 64'd1);
        #1 bus.FLUSH = 1'b1;
        idle();
        @(negedge CLK);
        chk("fp_target", bus.BR_TARGET,         64'h108);
        chk("fp_valid",  64'(bus.MEM_VALID),    64'd0);

        // RESET while FULL with MEM_READY low
        #1 bus.FLUSH = 1'b0;
        bus.MEM_READY = 1'b0;
        drive(1'b1, 64'h77, 1'b0, 64'd0, 64'd0, 2'b00, 64'h99, 5'd7, 4'b0101);
        @(negedge CLK);
        #1 drive(1'b1, 64'h88, 1'b1, 64'h500, 64'h3, 2'b10, 64'h66, 5'd9, 4'b0000);
        @(negedge CLK);
        chk("rf_ready", 64'(bus.EX_READY), 64'd0);
        #1 RESET = 1'b1;
        idle();
        @(negedge CLK);
        chk("rf_valid",  64'(bus.MEM_VALID),    64'd0);
        chk("rf_ready2", 64'(bus.EX_READY),     64'd1);
        chk("rf_alu",    bus.MEM_ALU,           64'd0);
        chk("rf_store",  bus.MEM_STORE,         64'd0);
        chk("rf_rd",     64'(bus.MEM_RD),       64'd0);
        chk("rf_ctrl",   64'(bus.MEM_CTRL),     64'd0);
        chk("rf_pulse",  64'(bus.BRANCH_TAKEN), 64'd0);
        chk("rf_target", bus.BR_TARGET,         64'd0);

        // Randomized traffic
        #1 RESET = 1'b0;
        for (int i = 0; i < 300; i++) begin
            bus.MEM_READY = ($urandom_range(0, 3) != 0);
            bus.FLUSH     = ($urandom_range(0, 31) == 0);
            drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                  {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)),
                  {$urandom, $urandom}, 5'($urandom), 4'($urandom));
            @(negedge CLK);
            #1;
        end
        bus.FLUSH = 1'b0;
        bus.MEM_READY = 1'b1;
        idle();
        repeat (4) @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
